// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width for a WIDTH-bit serial operation.
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial arithmetic blocks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first,
// computed as a + ~b + 1 through one full-adder cell and a carry flop.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .carry_in (carry_q),
        .sum      (fa_sum),
        .carry_out(fa_cout)
    );

    // in_ready is gated by rst so the source never sees a handshake during reset.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

    // Next-state and datapath: load in IDLE, one bit per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish the result only once complete; diff holds it until the next DONE.
                    diff_d   = {fa_sum, res_q[WIDTH-1:1]};
                    borrow_d = ~fa_cout;
                    ovf_d    = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
